// File: rtl/pixel_ctrl_pkg.sv
// Shared definitions for the pixel frame sequencer.
//   state_t    : frame sequencer states
//   DEF_*      : default sizing constants
//   phase_len  : number of cycles a state lasts once entered
//   max2       : integer max, used for counter sizing
package pixel_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READ,
        S_GAP,
        S_DONE
    } state_t;

    localparam int DEF_NUM_ROWS = 2;
    localparam int DEF_ADC_BITS = 8;
    localparam int DEF_C_ERASE  = 5;
    localparam int DEF_C_READ   = 4;
    localparam int DEF_EXP_BITS = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // An exposure of 0 cycles is stretched to 1 so EXPOSE is never skipped.
    function automatic int phase_len(input state_t s, input int exp_cycles,
                                     input int adc_bits, input int c_erase,
                                     input int c_read);
        case (s)
            S_ERASE:   return c_erase;
            S_EXPOSE:  return (exp_cycles == 0) ? 1 : exp_cycles;
            S_CONVERT: return 1 << adc_bits;
            S_READ:    return c_read;
            default:   return 1;
        endcase
    endfunction

endpackage

// File: rtl/pixel_frame_ctrl_cycle_timer.sv
// Loadable down-counter timing every sequencer phase.
//   clk, reset : clock, async active-low reset
//   load       : load load_val this cycle (phase entry)
//   load_val   : phase length minus one
//   tc         : terminal count, high on the last cycle of the phase
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           cnt <= '0;
        else if (load)        cnt <= load_val;
        else if (cnt != '0)   cnt <= cnt - 1'b1;
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/pixel_frame_ctrl.sv
// Frame sequencer for the pixel array: erase -> expose -> convert -> row
// readout, with one idle turnaround cycle between row windows so no two rows
// ever drive the shared pixdata buses together.
//   clk, reset   : clock, async active-low reset
//   frame_en     : run frames (sampled in IDLE and DONE)
//   expose_len   : exposure cycles, latched at frame start
//   erase/expose/convert : global phase strobes
//   adc_count    : ramp count broadcast during convert, 0 otherwise
//   read_row     : one-hot row read select
//   row_idx      : current / last selected row
//   sample       : last cycle of a row window, pixdata valid
//   frame_done   : one-cycle end-of-frame pulse
//   busy         : high outside IDLE
module pixel_frame_ctrl
    import pixel_ctrl_pkg::*;
#(
    parameter int NUM_ROWS = DEF_NUM_ROWS,
    parameter int ADC_BITS = DEF_ADC_BITS,
    parameter int C_ERASE  = DEF_C_ERASE,
    parameter int C_READ   = DEF_C_READ,
    parameter int EXP_BITS = DEF_EXP_BITS,
    localparam int RW      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_en,
    input  logic [EXP_BITS-1:0] expose_len,
    output logic                erase,
    output logic                expose,
    output logic                convert,
    output logic [ADC_BITS-1:0] adc_count,
    output logic [NUM_ROWS-1:0] read_row,
    output logic [RW-1:0]       row_idx,
    output logic                sample,
    output logic                frame_done,
    output logic                busy
);

    // Timer must hold the longest phase minus one.
    localparam int TW = max2(max2(ADC_BITS, EXP_BITS),
                             max2($clog2(C_ERASE + 1), $clog2(C_READ + 1)));

    state_t              state, state_next;
    logic [EXP_BITS-1:0] exp_reg;
    logic [ADC_BITS-1:0] adc;
    logic [RW-1:0]       row;
    logic                tc;
    logic                load;
    logic [TW-1:0]       load_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (frame_en) state_next = S_ERASE;
            S_ERASE:   if (tc) state_next = S_EXPOSE;
            S_EXPOSE:  if (tc) state_next = S_CONVERT;
            S_CONVERT: if (tc) state_next = S_READ;
            S_READ:    if (tc) state_next = (row == RW'(NUM_ROWS - 1)) ? S_DONE : S_GAP;
            S_GAP:     state_next = S_READ;
            S_DONE:    state_next = frame_en ? S_ERASE : S_IDLE;
            default:   state_next = S_IDLE;
        endcase

        // Every state change starts a new phase; GAP always separates two
        // READ windows, so a state change is a reliable phase-entry marker.
        load     = (state_next != state);
        load_val = TW'(phase_len(state_next, int'(exp_reg), ADC_BITS, C_ERASE, C_READ) - 1);

        erase      = (state == S_ERASE);
        expose     = (state == S_EXPOSE);
        convert    = (state == S_CONVERT);
        read_row   = '0;
        sample     = 1'b0;
        if (state == S_READ) begin
            read_row = NUM_ROWS'(1) << row;
            sample   = tc;
        end
        frame_done = (state == S_DONE);
        busy       = (state != S_IDLE);
    end

    cycle_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .tc       (tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            exp_reg <= '0;
        else if ((state == S_IDLE || state == S_DONE) && frame_en)
            exp_reg <= expose_len;
    end

    // Count is zero on entry and clears as the phase ends, so it reads 0 in
    // every state other than CONVERT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            adc <= '0;
        else if (state == S_CONVERT && state_next == S_CONVERT)
            adc <= adc + 1'b1;
        else
            adc <= '0;
    end

    // row keeps the last selected row through DONE and into a back-to-back
    // frame; it only clears on return to IDLE or at the start of readout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            row <= '0;
        else if (state == S_CONVERT && state_next == S_READ)
            row <= '0;
        else if (state == S_GAP)
            row <= row + 1'b1;
        else if (state_next == S_IDLE)
            row <= '0;
    end

    assign adc_count = adc;
    assign row_idx   = row;

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
module tb_pixel_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_en;
    logic [7:0] expose_len;
    logic       erase, expose, convert, sample, frame_done, busy;
    logic [7:0] adc_count;
    logic [1:0] read_row;
    logic [0:0] row_idx;

    always #5 clk = ~clk;

    pixel_frame_ctrl #(
        .NUM_ROWS (2),
        .ADC_BITS (8),
        .C_ERASE  (5),
        .C_READ   (4),
        .EXP_BITS (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_en   (frame_en),
        .expose_len (expose_len),
        .erase      (erase),
        .expose     (expose),
        .convert    (convert),
        .adc_count  (adc_count),
        .read_row   (read_row),
        .row_idx    (row_idx),
        .sample     (sample),
        .frame_done (frame_done),
        .busy       (busy)
    );

    typedef struct packed {
        logic       erase;
        logic       expose;
        logic       convert;
        logic [7:0] adc;
        logic [1:0] rrow;
        logic       ridx;
        logic       samp;
        logic       done;
        logic       busy;
    } ov_t;

    ov_t sb_q[$];
    int  checks = 0;
    int  failures = 0;
    logic mon_en = 1'b0;
    int  win_cnt = 0;
    int  samp_cnt = 0;
    int  mon_frames = 0;

    function automatic ov_t cur_obs();
        return {erase, expose, convert, adc_count, read_row, row_idx, sample, frame_done, busy};
    endfunction

    // Expected cycle-by-cycle outputs of one frame, built from the phase
    // lengths. start_idx is row_idx carried in from the previous frame.
    task automatic push_frame(input int e, input logic start_idx);
        ov_t v;
        int  ee;
        ee = (e == 0) ? 1 : e;
        for (int i = 0; i < 5; i++) begin
            v = '0; v.erase = 1'b1; v.ridx = start_idx; v.busy = 1'b1; sb_q.push_back(v);
        end
        for (int i = 0; i < ee; i++) begin
            v = '0; v.expose = 1'b1; v.ridx = start_idx; v.busy = 1'b1; sb_q.push_back(v);
        end
        for (int i = 0; i < 256; i++) begin
            v = '0; v.convert = 1'b1; v.adc = 8'(i); v.ridx = start_idx; v.busy = 1'b1;
            sb_q.push_back(v);
        end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                v = '0; v.rrow = 2'(1 << r); v.ridx = 1'(r); v.samp = (c == 3); v.busy = 1'b1;
                sb_q.push_back(v);
            end
            if (r == 0) begin
                v = '0; v.ridx = 1'b0; v.busy = 1'b1; sb_q.push_back(v);
            end
        end
        v = '0; v.ridx = 1'b1; v.done = 1'b1; v.busy = 1'b1; sb_q.push_back(v);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) sb_q.push_back('0);
    endtask

    task automatic run_check(input int n, input string tag);
        ov_t obs, ev;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs = cur_obs();
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL %s cycle %0d: scoreboard empty, got %h", tag, i, obs);
            end else begin
                ev = sb_q.pop_front();
                if (obs !== ev) begin
                    failures++;
                    $display("FAIL %s cycle %0d: got er/ex/cv=%b%b%b adc=%0d row=%b idx=%0d s=%b d=%b busy=%b, expected er/ex/cv=%b%b%b adc=%0d row=%b idx=%0d s=%b d=%b busy=%b",
                             tag, i, obs.erase, obs.expose, obs.convert, obs.adc, obs.rrow, obs.ridx,
                             obs.samp, obs.done, obs.busy, ev.erase, ev.expose, ev.convert, ev.adc,
                             ev.rrow, ev.ridx, ev.samp, ev.done, ev.busy);
                end
            end
        end
    endtask

    // Invariant monitor
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ((int'(erase) + int'(expose) + int'(convert)) > 1) begin
                failures++;
                $display("FAIL phase_exclusive: got er/ex/cv=%b%b%b, at most one high", erase, expose, convert);
            end
            checks++;
            if ($countones(read_row) > 1) begin
                failures++;
                $display("FAIL read_row_onehot: got %b, popcount must be <= 1", read_row);
            end
            checks++;
            if (!convert && adc_count != 8'd0) begin
                failures++;
                $display("FAIL adc_zero: got adc_count=%0d with convert=0, expected 0", adc_count);
            end
            if (read_row != 2'b00) win_cnt++;
            else                   win_cnt = 0;
            if (sample) begin
                checks++;
                if (win_cnt != 4 || read_row != (2'b01 << samp_cnt)) begin
                    failures++;
                    $display("FAIL sample_pos: got window cycle %0d read_row=%b, expected cycle 4 read_row=%b",
                             win_cnt, read_row, 2'b01 << samp_cnt);
                end
                samp_cnt++;
            end
            if (frame_done) begin
                checks++;
                if (samp_cnt != 2) begin
                    failures++;
                    $display("FAIL samples_per_frame: got %0d, expected 2", samp_cnt);
                end
                samp_cnt = 0;
                mon_frames++;
            end
        end
    end

    task automatic test_reset();
        ov_t obs;
        reset = 1'b0; frame_en = 1'b1; expose_len = 8'd10;
        repeat (3) @(negedge clk);
        obs = cur_obs();
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h, expected 0", obs);
        end
        reset = 1'b1;
        mon_en = 1'b1;
    endtask

    // Frame A exposes 10 even though expose_len drops to 3 mid-expose;
    // frame B picks up the 3.
    task automatic test_expose_len_change();
        push_frame(10, 1'b0);
        run_check(8, "frameA");
        expose_len = 8'd3;
        run_check(273, "frameA");
        push_frame(3, 1'b1);
        run_check(50, "frameB");
        expose_len = 8'd0;
        run_check(224, "frameB");
    endtask

    task automatic test_expose_zero_en_drop();
        push_frame(0, 1'b1);
        run_check(16, "expose0");
        frame_en = 1'b0;
        run_check(256, "expose0");
        push_idle(4);
        run_check(4, "idle_after_drop");
    endtask

    task automatic test_back_to_back();
        int start;
        start = mon_frames;
        expose_len = 8'd2;
        frame_en = 1'b1;
        push_frame(2, 1'b0);
        for (int f = 1; f < 5; f++) push_frame(2, 1'b1);
        run_check(4 * 273 + 200, "b2b");
        frame_en = 1'b0;
        run_check(73, "b2b");
        push_idle(3);
        run_check(3, "b2b_idle");
        checks++;
        if (mon_frames - start != 5) begin
            failures++;
            $display("FAIL b2b_frames: got %0d frame_done pulses, expected 5", mon_frames - start);
        end
    endtask

    task automatic test_reset_mid_read();
        ov_t obs;
        frame_en = 1'b1;
        expose_len = 8'd1;
        push_frame(1, 1'b0);
        run_check(268, "to_row1");
        mon_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        obs = cur_obs();
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL async_reset: got %h before next edge, expected 0", obs);
        end
        sb_q.delete();
        @(negedge clk);
        reset = 1'b1;
        frame_en = 1'b0;
        push_idle(5);
        run_check(5, "post_reset_idle");
        frame_en = 1'b1;
        push_frame(1, 1'b0);
        run_check(10, "restart");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_expose_len_change();
        test_expose_zero_en_drop();
        test_back_to_back();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
